argmax_decision: RTL

Final classification stage of the decision path. It sits directly downstream of the fp16 column-reduction block and consumes its stream of per-class fp16 sums, one sum per valid_in pulse, in class order 0..NUM_CLASSES-1. Once a full frame has arrived, it emits the index of the largest score as the network's predicted class. There is no backpressure: the upstream reduction stage cannot be stalled, so every valid_in beat is accepted.

---
 rtl/decision_pkg.sv | 20 ++
 rtl/fp16_gt.sv | 41 ++++
 rtl/argmax_decision.sv | 138 +++++++++++++
 3 files changed

// File: rtl/decision_pkg.sv
// Shared types, fp16 field masks and helpers for the decision-path logic.
// Pure declarations; no latency.
// No flow control of its own; consumers decide backpressure.
package decision_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [15:0] FP16_EXP_MASK  = 16'h7C00;
  localparam logic [15:0] FP16_MANT_MASK = 16'h03FF;
  localparam int          FP16_SIGN_BIT  = 15;

  // NaN: exponent all ones with a non-zero mantissa (infinities excluded).
  function automatic logic is_nan(input logic [15:0] x);
    return ((x & FP16_EXP_MASK) == FP16_EXP_MASK) && ((x & FP16_MANT_MASK) != 16'h0000);
  endfunction

endpackage

// File: rtl/fp16_gt.sv
// Strict fp16 greater-than: a_gt_b = (a > b), NaN below everything, +0 == -0.
// Latency: purely combinational.
// No flow control; evaluates every cycle.
module fp16_gt
  import decision_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        a_gt_b
);

  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_both_zero;
  logic [15:0] w_a_key;
  logic [15:0] w_b_key;

  assign w_a_nan     = is_nan(a);
  assign w_b_nan     = is_nan(b);
  assign w_both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);

  // Map sign-magnitude onto an unsigned ordering: negatives are inverted so a
  // larger magnitude sorts lower, positives get the top bit set to sort above.
  assign w_a_key = a[FP16_SIGN_BIT] ? ~a : (a ^ 16'h8000);
  assign w_b_key = b[FP16_SIGN_BIT] ? ~b : (b ^ 16'h8000);

  // NaN never wins; any number beats NaN; signed zeros tie; otherwise key order.
  always_comb begin
    a_gt_b = 1'b0;
    if (w_a_nan) begin
      a_gt_b = 1'b0;
    end else if (w_b_nan) begin
      a_gt_b = 1'b1;
    end else if (w_both_zero) begin
      a_gt_b = 1'b0;
    end else begin
      a_gt_b = (w_a_key > w_b_key);
    end
  end

endmodule

// File: rtl/argmax_decision.sv
// Argmax over a frame of NUM_CLASSES fp16 scores; emits the winning class index.
// Latency: valid_out pulses 1 cycle after the edge accepting the last score.
// No backpressure: every valid_in beat is accepted, gaps allowed. Option: ARGMAX_SCORE_OUT_EN adds max_score.
module argmax_decision
  import decision_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] score_in,
  output logic                  valid_out,
  output logic [IDX_W-1:0]      class_out,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0] max_score,
`endif
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_best_val;
  logic [IDX_W-1:0]      r_best_idx;
  logic [IDX_W-1:0]      r_class_out;
  logic                  r_valid_out;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DATA_WIDTH-1:0] w_best_val_nxt;
  logic [IDX_W-1:0]      w_best_idx_nxt;
  logic [IDX_W-1:0]      w_class_nxt;
  logic                  w_valid_nxt;
  logic                  w_gt;

`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_WIDTH-1:0] r_max_score;
  logic [DATA_WIDTH-1:0] w_max_score_nxt;
`endif

  fp16_gt u_gt (
    .a      (score_in),
    .b      (r_best_val),
    .a_gt_b (w_gt)
  );

  // State register plus all datapath registers of the frame accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_class_out <= '0;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_best_val  <= w_best_val_nxt;
      r_best_idx  <= w_best_idx_nxt;
      r_class_out <= w_class_nxt;
      r_valid_out <= w_valid_nxt;
      r_busy      <= (w_state_nxt == ACCUM);
    end
  end

`ifdef ARGMAX_SCORE_OUT_EN
  // Winning value, captured together with class_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_score <= '0;
    end else begin
      r_max_score <= w_max_score_nxt;
    end
  end
`endif

  // Next-state and datapath: score 0 seeds the best, later scores replace it
  // only on strict greater-than so ties keep the lower index.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_best_val_nxt = r_best_val;
    w_best_idx_nxt = r_best_idx;
    w_class_nxt    = r_class_out;
    w_valid_nxt    = 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
    w_max_score_nxt = r_max_score;
`endif
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_best_val_nxt = score_in;
          w_best_idx_nxt = '0;
          w_idx_nxt      = IDX_W'(1);
          w_state_nxt    = ACCUM;
        end
      end
      ACCUM: begin
        if (valid_in) begin
          if (w_gt) begin
            w_best_val_nxt = score_in;
            w_best_idx_nxt = r_idx;
          end
          if (r_idx == LAST_IDX) begin
            w_class_nxt = w_gt ? r_idx : r_best_idx;
`ifdef ARGMAX_SCORE_OUT_EN
            w_max_score_nxt = w_gt ? score_in : r_best_val;
`endif
            w_valid_nxt = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign valid_out = r_valid_out;
  assign class_out = r_class_out;
  assign busy      = r_busy;
`ifdef ARGMAX_SCORE_OUT_EN
  assign max_score = r_max_score;
`endif

endmodule
